fp_fir_coeff_loader: RTL and testbench

Writer side of the FIR coefficient bank. Accepts IEEE-754 single-precision coefficients over a valid/ready stream and assembles them into a shadow bank. At a sample boundary signalled by the filter, it swaps that bank in as the active bank. This replaces hierarchical coefficient pokes and lets a 31-tap FP band-pass FIR be retuned at run time without corrupting an output sample.

---
 rtl/fp_fir_coeff_loader_if.sv | 22 ++
 rtl/fp_fir_coeff_loader.sv | 143 ++++++++++++++
 tb/tb_fp_fir_coeff_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_fir_coeff_loader_if.sv
// Coefficient word stream into the FIR coefficient loader.
// The producer drives valid/data/last and the loader answers with ready.
interface fp_fir_coeff_loader_if;
    logic        coef_valid;
    logic        coef_ready;
    logic [31:0] coef_data;
    logic        coef_last;

    modport master (
        output coef_valid,
        output coef_data,
        output coef_last,
        input  coef_ready
    );

    modport slave (
        input  coef_valid,
        input  coef_data,
        input  coef_last,
        output coef_ready
    );
endinterface

// File: rtl/fp_fir_coeff_loader.sv
// Double-buffered FP32 FIR coefficient bank: streams a load into the shadow bank,
// then swaps it in as the active bank at a sample boundary signalled by the filter.
module fp_fir_coeff_loader #(
    parameter int TAP_CNT   = 31,
    parameter bit SYMMETRIC = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fp_fir_coeff_loader_if.slave    coef,
    input  logic                    swap_ok,
    output logic [TAP_CNT*32-1:0]   coeffs_flat,
    output logic                    bank_sel,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_err
);
    localparam int WORD_CNT = SYMMETRIC ? (TAP_CNT + 1) / 2 : TAP_CNT;
    localparam int IDX_W    = (WORD_CNT > 1) ? $clog2(WORD_CNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_CNT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP, DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             bad_reg, bad_next;
    logic             bank_sel_reg, bank_sel_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             accept;
    logic             word_bad;
    logic             cur_bad;
    logic             wr_en;
    logic [IDX_W-1:0] cur_idx;

    assign coef.coef_ready = rst_n && (state_reg != WAIT_SWAP);
    assign accept          = coef.coef_valid && coef.coef_ready;
    // Exponent all ones means NaN or Inf.
    assign word_bad        = &coef.coef_data[30:23];

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        bad_next      = bad_reg;
        bank_sel_next = bank_sel_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        wr_en         = 1'b0;
        // IDLE acts as LOAD at index 0 with a freshly cleared bad flag.
        cur_idx       = (state_reg == IDLE) ? '0 : idx_reg;
        cur_bad       = ((state_reg == LOAD) && bad_reg) || word_bad;
        case (state_reg)
            IDLE, LOAD: begin
                if (accept) begin
                    wr_en    = 1'b1;
                    bad_next = cur_bad;
                    idx_next = cur_idx + IDX_W'(1);
                    if (cur_idx == LAST_IDX) begin
                        if (coef.coef_last && !cur_bad) begin
                            state_next = WAIT_SWAP;
                        end else begin
                            err_next   = 1'b1;
                            state_next = coef.coef_last ? IDLE : DRAIN;
                        end
                    end else if (coef.coef_last) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (accept && coef.coef_last) begin
                    state_next = IDLE;
                end
            end
            WAIT_SWAP: begin
                if (swap_ok) begin
                    bank_sel_next = !bank_sel_reg;
                    done_next     = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            bad_reg      <= 1'b0;
            bank_sel_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            bad_reg      <= bad_next;
            bank_sel_reg <= bank_sel_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    // Per-tap storage: two banks plus the registered active copy.
    for (genvar gi = 0; gi < TAP_CNT; gi++) begin : g_tap
        localparam int MIRROR = TAP_CNT - 1 - gi;
        logic [31:0] bank0_reg;
        logic [31:0] bank1_reg;
        logic [31:0] active_reg;
        logic        hit;

        assign hit = wr_en && ((int'(cur_idx) == gi) ||
                               (SYMMETRIC && (int'(cur_idx) == MIRROR)));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bank0_reg  <= '0;
                bank1_reg  <= '0;
                active_reg <= '0;
            end else begin
                if (hit && bank_sel_reg) begin
                    bank0_reg <= coef.coef_data;
                end
                if (hit && !bank_sel_reg) begin
                    bank1_reg <= coef.coef_data;
                end
                // The shadow bank becomes active on the swap edge.
                if (done_next) begin
                    active_reg <= bank_sel_reg ? bank0_reg : bank1_reg;
                end
            end
        end

        assign coeffs_flat[32*gi +: 32] = active_reg;
    end

    assign bank_sel  = bank_sel_reg;
    assign busy      = (state_reg != IDLE);
    assign load_done = done_reg;
    assign load_err  = err_reg;
endmodule

// File: tb/tb_fp_fir_coeff_loader.sv
// Self-checking bench for fp_fir_coeff_loader: table vectors, random loads against a
// transaction-level bank model, reset corner cases and a non-symmetric instance.
module tb_fp_fir_coeff_loader;
    localparam int TAP = 31;
    localparam int N   = (TAP + 1) / 2;

    logic clk;
    logic rst_n;
    logic swap_ok;
    logic [TAP*32-1:0] coeffs_flat, ns_coeffs_flat;
    logic bank_sel, busy, load_done, load_err;
    logic ns_bank_sel, ns_busy, ns_load_done, ns_load_err;

    fp_fir_coeff_loader_if sif ();
    fp_fir_coeff_loader_if nif ();

    fp_fir_coeff_loader #(.TAP_CNT(TAP), .SYMMETRIC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .coef(sif), .swap_ok(swap_ok),
        .coeffs_flat(coeffs_flat), .bank_sel(bank_sel), .busy(busy),
        .load_done(load_done), .load_err(load_err)
    );

    fp_fir_coeff_loader #(.TAP_CNT(TAP), .SYMMETRIC(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .coef(nif), .swap_ok(swap_ok),
        .coeffs_flat(ns_coeffs_flat), .bank_sel(ns_bank_sel), .busy(ns_busy),
        .load_done(ns_load_done), .load_err(ns_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0]       words [0:31];
    logic [TAP*32-1:0] model_flat;
    logic              model_sel;

    typedef struct {
        int          len;
        int          bad_pos;
        logic [31:0] bad_val;
        int          delay;
        bit          exp_ok;
        int          exp_err;
    } vec_t;
    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bank(input string name, input logic [TAP*32-1:0] act,
                            input logic [TAP*32-1:0] exp);
        int first;
        checks++;
        if (act !== exp) begin
            errors++;
            first = 0;
            for (int i = TAP - 1; i >= 0; i--)
                if (act[32*i +: 32] !== exp[32*i +: 32]) first = i;
            $display("FAIL %s: tap %0d got %08h expected %08h", name, first,
                     act[32*first +: 32], exp[32*first +: 32]);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (&w[30:23]) w[30] = 1'b0;
        return w;
    endfunction

    // Mirrored bank: tap i holds word min(i, TAP-1-i).
    function automatic logic [TAP*32-1:0] expand_sym();
        logic [TAP*32-1:0] f;
        f = '0;
        for (int i = 0; i < TAP; i++)
            f[32*i +: 32] = words[(i < TAP - 1 - i) ? i : TAP - 1 - i];
        return f;
    endfunction

    // A load succeeds only with exactly N words and no NaN/Inf among them.
    function automatic bit model_ok(input int len);
        if (len != N) return 1'b0;
        for (int i = 0; i < N; i++)
            if (&words[i][30:23]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int model_err_word(input int len);
        return (len < N) ? len : N;
    endfunction

    task automatic send_words(input int len, output int err_pulses, output int err_at,
                              output int done_pulses, output bit ready_ok, output bit busy_mid);
        err_pulses = 0; err_at = -1; done_pulses = 0; ready_ok = 1'b1; busy_mid = 1'b1;
        for (int w = 0; w < len; w++) begin
            sif.coef_valid = 1'b1;
            sif.coef_data  = words[w];
            sif.coef_last  = (w == len - 1);
            if (sif.coef_ready !== 1'b1) ready_ok = 1'b0;
            step();
            if (load_err === 1'b1) begin
                err_pulses++;
                err_at = w + 1;
            end
            if (load_done === 1'b1) done_pulses++;
            if (w == N - 1 && w < len - 1) busy_mid = busy;
        end
        sif.coef_valid = 1'b0;
        sif.coef_last  = 1'b0;
    endtask

    task automatic run_load(input int len, input int delay, input bit exp_ok,
                            input int exp_err, input string tag);
        int ep, ea, dp;
        bit rdy, bm, ok;
        swap_ok = (delay == 0);
        send_words(len, ep, ea, dp, rdy, bm);
        chk({tag, "_ready"}, rdy, 1);
        chk({tag, "_early_done"}, dp, 0);
        if (exp_ok) begin
            chk({tag, "_noerr"}, ep, 0);
            chk({tag, "_wait"}, {busy, sif.coef_ready, bank_sel}, {1'b1, 1'b0, model_sel});
            ok = 1'b1;
            for (int c = 0; c < delay; c++) begin
                step();
                if (sif.coef_ready !== 1'b0 || busy !== 1'b1 || load_done !== 1'b0) ok = 1'b0;
                if (coeffs_flat !== model_flat || bank_sel !== model_sel) ok = 1'b0;
            end
            if (delay > 0) chk({tag, "_hold"}, ok, 1);
            swap_ok = 1'b1;
            step();
            model_flat = expand_sym();
            model_sel  = ~model_sel;
            chk({tag, "_swap"}, {bank_sel, load_done, load_err}, {model_sel, 1'b1, 1'b0});
            chk_bank({tag, "_coeffs"}, coeffs_flat, model_flat);
            step();
            chk({tag, "_after"}, {load_done, busy, sif.coef_ready}, {1'b0, 1'b0, 1'b1});
        end else begin
            chk({tag, "_err_cnt"}, ep, 1);
            chk({tag, "_err_word"}, ea, exp_err);
            if (len > N) chk({tag, "_drain_busy"}, bm, 1);
            swap_ok = 1'b1;
            ok = 1'b1;
            repeat (3) begin
                step();
                if (load_done !== 1'b0 || load_err !== 1'b0) ok = 1'b0;
            end
            chk({tag, "_no_pulse"}, ok, 1);
            chk({tag, "_idle"}, {bank_sel, busy, sif.coef_ready}, {model_sel, 1'b0, 1'b1});
            chk_bank({tag, "_kept"}, coeffs_flat, model_flat);
        end
        swap_ok = 1'b0;
        $display("load %s len=%0d delay=%0d expect_ok=%0d bank_sel=%0d", tag, len, delay,
                 exp_ok, bank_sel);
    endtask

    initial begin
        int ep, ea, dp, len, sel, d;
        bit rdy, bm, ok;
        logic [TAP*32-1:0] ns_exp;

        vecs[0] = '{16, -1, 32'h0,        10, 1'b1, 0};
        vecs[1] = '{ 9, -1, 32'h0,         0, 1'b0, 9};
        vecs[2] = '{16, -1, 32'h0,         2, 1'b1, 0};
        vecs[3] = '{20, -1, 32'h0,         0, 1'b0, 16};
        vecs[4] = '{16,  4, 32'h7fc00000,  0, 1'b0, 16};
        vecs[5] = '{ 1, -1, 32'h0,         0, 1'b0, 1};
        vecs[6] = '{16, 15, 32'h7f800000,  0, 1'b0, 16};
        vecs[7] = '{16, -1, 32'h0,         0, 1'b1, 0};

        rst_n = 1'b0; swap_ok = 1'b0;
        sif.coef_valid = 1'b0; sif.coef_data = '0; sif.coef_last = 1'b0;
        nif.coef_valid = 1'b0; nif.coef_data = '0; nif.coef_last = 1'b0;
        model_flat = '0; model_sel = 1'b0;
        step();
        chk("reset_ready_low", sif.coef_ready, 0);
        rst_n = 1'b1;
        step();
        chk("reset_state", {sif.coef_ready, busy, bank_sel, load_done, load_err}, 5'b10000);
        chk_bank("reset_coeffs", coeffs_flat, '0);

        // Basic mirrored load with the reference boundary words.
        for (int w = 0; w < 32; w++) words[w] = rand_word();
        words[0] = 32'hbb306eeb; words[14] = 32'h3dacccb2; words[15] = 32'h3db43958;
        run_load(16, 0, 1'b1, 0, "basic");
        chk("tap0",  coeffs_flat[0*32 +: 32],  32'hbb306eeb);
        chk("tap30", coeffs_flat[30*32 +: 32], 32'hbb306eeb);
        chk("tap15", coeffs_flat[15*32 +: 32], 32'h3db43958);
        chk("tap14", coeffs_flat[14*32 +: 32], 32'h3dacccb2);
        chk("tap16", coeffs_flat[16*32 +: 32], 32'h3dacccb2);

        for (int i = 0; i < 8; i++) begin
            for (int w = 0; w < 32; w++) words[w] = rand_word();
            if (vecs[i].bad_pos >= 0) words[vecs[i].bad_pos] = vecs[i].bad_val;
            run_load(vecs[i].len, vecs[i].delay, vecs[i].exp_ok, vecs[i].exp_err,
                     $sformatf("vec%0d", i));
        end

        for (int r = 0; r < 10; r++) begin
            for (int w = 0; w < 32; w++) words[w] = rand_word();
            sel = $urandom_range(0, 3);
            if (sel < 2)       len = N;
            else if (sel == 2) len = $urandom_range(1, N - 1);
            else               len = $urandom_range(N + 1, N + 4);
            if ($urandom_range(0, 3) == 0)
                words[$urandom_range(0, len - 1)] = $urandom_range(0, 1) ? 32'h7fc00000 : 32'hff800000;
            d = $urandom_range(0, 3);
            run_load(len, d, model_ok(len), model_err_word(len), $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a load (during word 8).
        for (int w = 0; w < 32; w++) words[w] = rand_word();
        for (int w = 0; w < 7; w++) begin
            sif.coef_valid = 1'b1; sif.coef_data = words[w]; sif.coef_last = 1'b0;
            step();
        end
        sif.coef_data = words[7];
        #2 rst_n = 1'b0;
        #1;
        chk("rst_load_outs", {sif.coef_ready, busy, bank_sel, load_done, load_err}, 5'b0);
        chk_bank("rst_load_coeffs", coeffs_flat, '0);
        sif.coef_valid = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        model_sel = 1'b0; model_flat = '0;
        chk("rst_load_release", {sif.coef_ready, busy}, 2'b10);
        step();
        $display("reset during load word 8 bank_sel=%0d", bank_sel);
        for (int w = 0; w < 32; w++) words[w] = rand_word();
        run_load(16, 1, 1'b1, 0, "post_rst");

        // Reset while waiting for the swap: no swap may follow.
        for (int w = 0; w < 32; w++) words[w] = rand_word();
        swap_ok = 1'b0;
        send_words(16, ep, ea, dp, rdy, bm);
        step();
        chk("rst_wait_busy", {busy, sif.coef_ready}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait_outs", {sif.coef_ready, busy, bank_sel, load_done}, 4'b0);
        chk_bank("rst_wait_coeffs", coeffs_flat, '0);
        step();
        rst_n = 1'b1;
        swap_ok = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            step();
            if (load_done !== 1'b0) ok = 1'b0;
        end
        chk("rst_wait_noswap", {ok, bank_sel, busy, sif.coef_ready}, {1'b1, 1'b0, 1'b0, 1'b1});
        chk_bank("rst_wait_kept", coeffs_flat, '0);
        swap_ok = 1'b0;
        $display("reset during wait_swap bank_sel=%0d", bank_sel);

        // Non-symmetric instance: every tap loaded independently.
        for (int w = 0; w < 32; w++) words[w] = rand_word();
        ok = 1'b1;
        for (int w = 0; w < TAP; w++) begin
            nif.coef_valid = 1'b1; nif.coef_data = words[w]; nif.coef_last = (w == TAP - 1);
            step();
            if (ns_load_err !== 1'b0) ok = 1'b0;
        end
        nif.coef_valid = 1'b0; nif.coef_last = 1'b0;
        swap_ok = 1'b1;
        chk("ns_noerr_wait", {ok, ns_busy, nif.coef_ready}, 3'b110);
        step();
        ns_exp = '0;
        for (int i = 0; i < TAP; i++) ns_exp[32*i +: 32] = words[i];
        chk("ns_swap", {ns_bank_sel, ns_load_done}, 2'b11);
        chk_bank("ns_coeffs", ns_coeffs_flat, ns_exp);
        swap_ok = 1'b0;
        step();
        $display("load ns len=%0d bank_sel=%0d", TAP, ns_bank_sel);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
